// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: shared constants and byte-merge helper for the data SRAM responder
package data_sram_resp_pkg;
  localparam logic [15:0] MMIO_BASE_HI_DEF = 16'hBFAF;
  localparam logic [15:0] MMIO_LED = 16'h0000;
  localparam logic [15:0] MMIO_SWITCH = 16'h0004;
  localparam logic [15:0] MMIO_TIMER = 16'h0008;
  localparam logic [15:0] MMIO_NUM = 16'h000C;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
  function automatic logic [31:0] merge_bytes(input logic [31:0] cur, input logic [31:0] wdata, input logic [3:0] wen);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wen[i] ? wdata[8*i +: 8] : cur[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/data_sram_resp_ram.sv
// byte_we_ram: word RAM with byte write enables, read-first registered output
module byte_we_ram
  import data_sram_resp_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic [3:0]    wen,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [0:(1<<AW)-1];
  // byte-masked write into the array, which is never reset
  always_ff @(posedge clk)
    if (en)
      for (int i = 0; i < 4; i++)
        if (wen[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
  // output register captures the word before this edge's write
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) rdata <= ZERO_WORD;
    else if (en) rdata <= mem[addr];
endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: data-side SRAM responder with RAM and a small MMIO register window
module data_sram_resp
  import data_sram_resp_pkg::*;
#(
  parameter int          ADDR_WIDTH   = 10,
  parameter logic [15:0] MMIO_BASE_HI = MMIO_BASE_HI_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  input  logic [15:0] switch_in,
  output logic [15:0] led,
  output logic [31:0] num_data
);
  logic        is_mmio, mmio_wr, sel_q, unused_bits;
  logic [15:0] off, sync1, sync2;
  logic [31:0] timer, mmio_rd, mmio_q, ram_rdata, led_m;
  assign is_mmio = data_sram_addr[31:16] == MMIO_BASE_HI;
  assign off = {data_sram_addr[15:2], 2'b00};
  assign mmio_wr = data_sram_en && is_mmio && |data_sram_wen;
  assign led_m = merge_bytes({16'h0000, led}, data_sram_wdata, data_sram_wen);
  assign unused_bits = ^{data_sram_addr[1:0], led_m[31:16]};
  assign data_sram_rdata = sel_q ? mmio_q : ram_rdata;
  // register window read value before this edge's write
  always_comb
    mmio_rd = off == MMIO_LED    ? {16'h0000, led} :
              off == MMIO_SWITCH ? {16'h0000, sync2} :
              off == MMIO_TIMER  ? timer :
              off == MMIO_NUM    ? num_data : ZERO_WORD;
  // two-flop synchroniser for the board switches
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= switch_in;
      sync2 <= sync1;
    end
  // MMIO registers; a TIMER write replaces that cycle's increment
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      led <= '0;
      num_data <= ZERO_WORD;
      timer <= ZERO_WORD;
    end else begin
      timer <= (mmio_wr && off == MMIO_TIMER) ? merge_bytes(timer, data_sram_wdata, data_sram_wen) : timer + 32'd1;
      if (mmio_wr && off == MMIO_LED) led <= led_m[15:0];
      if (mmio_wr && off == MMIO_NUM) num_data <= merge_bytes(num_data, data_sram_wdata, data_sram_wen);
    end
  // registered select and MMIO data, aligned with the RAM's registered output
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      sel_q <= 1'b0;
      mmio_q <= ZERO_WORD;
    end else if (data_sram_en) begin
      sel_q <= is_mmio;
      mmio_q <= mmio_rd;
    end
  byte_we_ram #(.AW(ADDR_WIDTH)) u_ram (
    .clk(clk),
    .resetn(resetn),
    .en(data_sram_en && !is_mmio),
    .wen(data_sram_wen),
    .addr(data_sram_addr[ADDR_WIDTH+1:2]),
    .wdata(data_sram_wdata),
    .rdata(ram_rdata)
  );
endmodule

// File: tb/tb_data_sram_resp.sv
// tb_data_sram_resp: directed and randomized checks of data_sram_resp against a behavioural model
module tb_data_sram_resp;
  localparam logic [31:0] MM = 32'hBFAF_0000;
  logic        clk, resetn, data_sram_en;
  logic [3:0]  data_sram_wen;
  logic [31:0] data_sram_addr, data_sram_wdata, data_sram_rdata, num_data;
  logic [15:0] switch_in, led;
  int n_pass = 0, n_total = 0;
  bit chk_on = 0;

  data_sram_resp dut (
    .clk(clk), .resetn(resetn), .data_sram_en(data_sram_en), .data_sram_wen(data_sram_wen),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata),
    .switch_in(switch_in), .led(led), .num_data(num_data)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // behavioural model: memory by word with per-byte known flags, registers as plain values
  logic [31:0] m_mem [1024];
  bit   [3:0]  m_kb [1024];
  logic [15:0] m_led, swv;
  logic [31:0] m_num, m_timer, m_rd, tnext;
  bit          m_rd_ok;
  logic [15:0] sw_q [$];
  int          o, w;
  initial for (int i = 0; i < 1024; i++) m_kb[i] = 4'b0000;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_led = 0; m_num = 0; m_timer = 0; m_rd = 0; m_rd_ok = 1;
      sw_q = '{16'h0, 16'h0};
    end else begin
      swv = sw_q[$-1];
      tnext = m_timer + 1;
      if (data_sram_en) begin
        o = int'(data_sram_addr[15:2]);
        w = int'(data_sram_addr[11:2]);
        if (data_sram_addr[31:16] == 16'hBFAF) begin
          m_rd_ok = 1;
          m_rd = o == 0 ? {16'h0, m_led} : o == 1 ? {16'h0, swv} : o == 2 ? m_timer : o == 3 ? m_num : 32'h0;
          if (o == 2 && data_sram_wen != 0) tnext = m_timer;
          for (int i = 0; i < 4; i++)
            if (data_sram_wen[i]) begin
              if (o == 0 && i < 2) m_led[8*i +: 8] = data_sram_wdata[8*i +: 8];
              if (o == 2) tnext[8*i +: 8] = data_sram_wdata[8*i +: 8];
              if (o == 3) m_num[8*i +: 8] = data_sram_wdata[8*i +: 8];
            end
        end else begin
          m_rd = m_mem[w];
          m_rd_ok = (m_kb[w] == 4'b1111);
          for (int i = 0; i < 4; i++)
            if (data_sram_wen[i]) begin
              m_mem[w][8*i +: 8] = data_sram_wdata[8*i +: 8];
              m_kb[w][i] = 1'b1;
            end
        end
      end
      m_timer = tnext;
      sw_q.push_back(switch_in);
      if (sw_q.size() > 4) void'(sw_q.pop_front());
    end
  end

  // every-cycle comparison against the model, away from the active edge
  always @(negedge clk)
    if (chk_on) begin
      if (m_rd_ok) check("model_rdata", data_sram_rdata, m_rd);
      check("model_led", {16'h0, led}, {16'h0, m_led});
      check("model_num", num_data, m_num);
    end

  task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] a, input logic [31:0] d);
    data_sram_en = en; data_sram_wen = wen; data_sram_addr = a; data_sram_wdata = d;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) req(0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    resetn = 0; data_sram_en = 0; data_sram_wen = 0; data_sram_addr = 0; data_sram_wdata = 0; switch_in = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_rdata", data_sram_rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num_data, 32'h0);
    @(negedge clk);
    resetn = 1; chk_on = 1;
    req(1, 4'h0, MM | 32'h8, 0);
    check("timer_first", data_sram_rdata, 32'h0);
    req(1, 4'h0, 32'h10, 0);
    check("led_zero", {16'h0, led}, 32'h0);
    check("num_zero", num_data, 32'h0);
    idle(3);
    req(1, 4'h0, MM | 32'h8, 0);
    check("timer_delta", data_sram_rdata, 32'd5);
    req(1, 4'hF, 32'h20, 32'h12345678);
    req(1, 4'h2, 32'h20, 32'hAABBCCDD);
    req(1, 4'h0, 32'h20, 0);
    check("byte_write", data_sram_rdata, 32'h1234CC78);
    req(1, 4'h0, 32'h1020, 0);
    check("alias", data_sram_rdata, 32'h1234CC78);
    req(1, 4'hF, 32'h40, 32'h11111111);
    req(1, 4'hF, 32'h40, 32'h22222222);
    check("read_first", data_sram_rdata, 32'h11111111);
    req(1, 4'h0, 32'h40, 0);
    check("write_then_read", data_sram_rdata, 32'h22222222);
    req(1, 4'hF, MM, 32'hFFFF5A5A);
    check("led_out", {16'h0, led}, 32'h5A5A);
    req(1, 4'h0, MM, 0);
    check("led_read", data_sram_rdata, 32'h00005A5A);
    req(1, 4'hC, MM, 32'h12340000);
    req(1, 4'h0, MM, 0);
    check("led_upper_ignored", data_sram_rdata, 32'h00005A5A);
    req(1, 4'h8, MM | 32'hC, 32'h7F000000);
    check("num_out", num_data, 32'h7F000000);
    req(1, 4'hF, MM | 32'h10, 32'hDEADBEEF);
    req(1, 4'h0, MM | 32'h10, 0);
    check("unmapped", data_sram_rdata, 32'h0);
    req(1, 4'hF, MM | 32'h8, 32'hFFFFFFFE);
    idle(3);
    req(1, 4'h0, MM | 32'h8, 0);
    check("timer_wrap", data_sram_rdata, 32'h00000001);
    switch_in = 16'h00F0;
    idle(1);
    req(1, 4'h0, MM | 32'h4, 0);
    check("switch_early", data_sram_rdata, 32'h0);
    req(1, 4'h0, MM | 32'h4, 0);
    check("switch_sync", data_sram_rdata, 32'h000000F0);
    resetn = 0;
    #1;
    check("midreset_rdata", data_sram_rdata, 32'h0);
    check("midreset_led", {16'h0, led}, 32'h0);
    check("midreset_num", num_data, 32'h0);
    @(negedge clk);
    resetn = 1;
    req(1, 4'h0, MM | 32'h8, 0);
    check("midreset_timer", data_sram_rdata, 32'h0);
    req(1, 4'h0, 32'h20, 0);
    check("ram_kept_20", data_sram_rdata, 32'h1234CC78);
    req(1, 4'h0, 32'h40, 0);
    check("ram_kept_40", data_sram_rdata, 32'h22222222);
    for (int k = 0; k < 500; k++) begin
      logic [31:0] a;
      logic [3:0] we;
      if ($urandom_range(0, 7) == 0) switch_in = 16'($urandom);
      a = $urandom_range(0, 2) == 0 ? (MM | (32'($urandom_range(0, 5)) << 2))
                                    : ($urandom & 32'h0000_F03C);
      a = a | 32'($urandom_range(0, 3));
      we = $urandom_range(0, 2) == 0 ? 4'h0 : 4'($urandom);
      req(1'($urandom_range(0, 3) != 0), we, a, $urandom);
    end
    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/data_sram_resp.md
# data_sram_resp

Responder for the CPU's data-side SRAM interface. It serves the core's enable/byte-write-enable/address/write-data requests and returns read data one cycle later. Behind the interface sit a word-addressed RAM and a small memory-mapped register window (LED, switches, timer, display number). The block sits at SoC level opposite the core's `data_sram_*` ports, replacing an external SRAM model so the core can run self-checking programs.

## Interface
Parameters:
- `ADDR_WIDTH`, 10: word-index bits; RAM depth is 2^ADDR_WIDTH 32-bit words.
- `MMIO_BASE_HI`, 16'hBFAF: value of `data_sram_addr[31:16]` that selects the register window.

Ports:
- `clk`, in, 1: single clock; everything is rising-edge.
- `resetn`, in, 1: asynchronous, active-low reset.
- `data_sram_en`, in, 1: request valid this cycle.
- `data_sram_wen`, in, 4: byte write enables; bit i covers `wdata[8i+7:8i]`. 4'b0000 means a read.
- `data_sram_addr`, in, 32: byte address; bits [1:0] are ignored.
- `data_sram_wdata`, in, 32: write data.
- `data_sram_rdata`, out, 32: read data for the previous cycle's request.
- `switch_in`, in, 16: asynchronous board switches.
- `led`, out, 16: LED register.
- `num_data`, out, 32: display-number register.

## Operation
- Decode:
  - MMIO when `addr[31:16] == MMIO_BASE_HI`.
  - Otherwise RAM at word index `addr[ADDR_WIDTH+1:2]`; upper bits are ignored, so addresses alias modulo the depth.
- MMIO offsets are taken from `addr[15:0]`:
  - 0x0000 LED: RW, low 16 bits; upper read bits are 0.
  - 0x0004 SWITCH: RO; returns the 2-flop-synchronised `switch_in` zero-extended; writes are ignored.
  - 0x0008 TIMER: RW, 32-bit, free-running +1 every cycle; wraps 0xFFFFFFFF→0.
  - 0x000C NUM: RW, 32-bit.
  - Any other offset reads 0; writes to it are dropped.
- Write: with `en`=1 and `wen`≠0, only the enabled bytes of the target are updated at the edge.
  - MMIO registers honour byte enables too. LED honours only wen[1:0].
- Read: with `en`=1, `rdata` is loaded at the edge with the target's value *before* that edge's write (read-first), including on write cycles.
- Idle: with `en`=0, `rdata` holds its last value and nothing changes except TIMER and the switch synchroniser.
- TIMER write: a write to TIMER takes priority over its increment. Written bytes take the new value and the other bytes keep the current value; there is no increment that cycle. Counting resumes the next cycle.
- Reset (`resetn`=0, at any time including mid-request): asynchronously clears `rdata`, LED, NUM, TIMER and the synchroniser flops to 0.
  - RAM contents are not reset.
  - A request coinciding with the reset release edge is ignored.

## Timing
- Read latency is exactly 1 cycle: a request at edge N produces `rdata` valid after edge N, stable for all of cycle N+1.
- Write latency is 1 edge. A read of the same address in the next cycle returns the new data. No stalls and no back-pressure; a new request may be issued every cycle.
- Back-to-back write then read of the same word in consecutive cycles returns the written data.
- A simultaneous write and read in the same cycle is impossible (one port); the read-first rule covers `rdata` on write cycles.
- `led` and `num_data` are driven directly from their registers. They change on the edge where the write is accepted.
- `switch_in` is visible in SWITCH reads 2 edges after it changes, plus 1 edge of read latency.
- TIMER read value is the count before the request edge. Two reads issued k cycles apart differ by k.

## Structure
- A shared package holds:
  - MMIO offsets: `MMIO_LED`, `MMIO_SWITCH`, `MMIO_TIMER`, `MMIO_NUM`.
  - The default `MMIO_BASE_HI`.
  - `ZERO_WORD`, reused from the existing defines.
- One sub-module, `byte_we_ram`: parameterised depth, 4 byte enables, read-first, registered output, no reset on the array.
- The top level contains:
  - address decode;
  - the MMIO register file, timer and synchroniser;
  - the rdata mux. RAM `rdata` already arrives registered, so the mux select must be registered to match.

## Test plan
- Reset, then read RAM 0x00000010: no write has been made, so the value is don't-care. Then check that `led`=0, `num_data`=0 and a TIMER read returns 0 issued in the first cycle after reset.
- Write 0x12345678 (wen=1111) to 0x00000020, then wen=0010 with wdata=0xAABBCCDD, then read → 0x1234CC78. Read 0x00001020 with ADDR_WIDTH=10 → the same word (alias).
- Read-first: the word at 0x40 holds 0x11111111; write 0x22222222 → `rdata` after that edge = 0x11111111; the next read = 0x22222222.
- MMIO: write 0xFFFF5A5A to LED → `led`=0x5A5A and a read returns 0x00005A5A. Write wen=1000 0x7F000000 to NUM → `num_data`=0x7F000000. Read offset 0x0010 → 0.
- Timer: write 0xFFFFFFFE, then idle 3 cycles and read → 0x00000001 (wrap), with exact cycle counting checked.
- Drive `switch_in`=0x00F0; a read 2 cycles later → 0x000000F0. Then assert `resetn` low mid-stream for 1 cycle → `rdata`, `led`, `num_data` and TIMER all read 0, and RAM still holds the previously written values.
